// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of mem_port_arbiter: packed per-requester access requests
// plus the one-hot grant and the shared read-return path.
interface mem_port_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 10,
  parameter int DW    = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    we;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between
// N_REQ requesters, with bounded burst locking and in-order read return.
module mem_port_arbiter #(
  parameter int N_REQ    = 3,
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int               IW       = $clog2(N_REQ);
  localparam logic [3:0]       LOCK_LIM = 4'(LOCK_MAX - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0]     ptr_r;
  logic [3:0]        lock_cnt_r;
  logic [RD_LAT-1:0] pipe_vld_r;
  logic [IW-1:0]     pipe_id_r [RD_LAT];

  logic              hit_s;
  logic [IW-1:0]     win_s;
  logic [IW-1:0]     cand_s;
  logic              take_s;
  logic              rv_s;

  // Requester index ptr+k, wrapped modulo N_REQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= N_REQ) ? IW'(s - N_REQ) : IW'(s);
  endfunction

  // Winner search: first requester at or after ptr, wrapping; nothing during reset.
  always_comb begin
    hit_s  = 1'b0;
    win_s  = '0;
    cand_s = '0;
    take_s = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = wrap_add(ptr_r, k);
      take_s = ~hit_s & ~rst & bus.req[cand_s];
      win_s  = take_s ? cand_s : win_s;
      hit_s  = hit_s | take_s;
    end
  end

  // Grant and memory mux; everything reads as zero when nobody is granted.
  always_comb begin
    bus.gnt   = hit_s ? (ONE_HOT0 << win_s) : '0;
    mem_en    = hit_s;
    mem_we    = hit_s & bus.we[win_s];
    mem_addr  = hit_s ? bus.addr[win_s*AW +: AW] : '0;
    mem_wdata = hit_s ? bus.wdata[win_s*DW +: DW] : '0;
  end

  // Read return: the oldest tracking stage lines up with mem_rdata.
  always_comb begin
    rv_s       = pipe_vld_r[RD_LAT-1] & ~rst;
    bus.rvalid = rv_s ? (ONE_HOT0 << pipe_id_r[RD_LAT-1]) : '0;
    bus.rdata  = rv_s ? mem_rdata : '0;
  end

  // Priority pointer and burst lock counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= '0;
      lock_cnt_r <= 4'd0;
    end else if (hit_s) begin
      // A locked owner keeps the pointer until LOCK_MAX grants have gone by.
      if (bus.lock[win_s] && (lock_cnt_r < LOCK_LIM)) begin
        ptr_r      <= win_s;
        lock_cnt_r <= lock_cnt_r + 4'd1;
      end else begin
        ptr_r      <= (win_s == IW'(N_REQ - 1)) ? '0 : win_s + IW'(1);
        lock_cnt_r <= 4'd0;
      end
    end else begin
      ptr_r      <= ptr_r;
      lock_cnt_r <= 4'd0;
    end
  end

  // Read-tracking pipeline, one stage per cycle of memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_r <= '0;
      for (int j = 0; j < RD_LAT; j++) begin
        pipe_id_r[j] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= hit_s & ~bus.we[win_s];
      pipe_id_r[0]  <= win_s;
      for (int j = 1; j < RD_LAT; j++) begin
        pipe_vld_r[j] <= pipe_vld_r[j-1];
        pipe_id_r[j]  <= pipe_id_r[j-1];
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two DUTs (RD_LAT 1 and 3) on shared stimulus,
// a cycle-level reference model, and hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int N = 3, AW = 10, DW = 16, LOCK_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req, we, lock;
  logic [29:0] addr;
  logic [47:0] wdata;

  logic [2:0]  gnt_a [2];
  logic [2:0]  rv_a  [2];
  logic [15:0] rd_a  [2];
  logic        men_a [2];
  logic        mwe_a [2];
  logic [9:0]  maddr_a [2];
  logic [15:0] mwd_a [2];

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 37) ^ 16'hC35A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_port_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] mem [1024];
    logic        wr  [1024];
    logic [15:0] rpipe [4];

    assign bus.req   = req;
    assign bus.we    = we;
    assign bus.lock  = lock;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;

    mem_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(LAT), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous memory: unwritten words read back as pat(address).
    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr[mem_addr]  <= 1'b1;
      end
      rpipe[0] <= (mem_en && !mem_we) ?
                  ((wr[mem_addr] === 1'b1) ? mem[mem_addr] : pat(int'(mem_addr))) : 16'h0000;
      for (int j = 1; j < 4; j++) rpipe[j] <= rpipe[j-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    assign gnt_a[g]   = bus.gnt;
    assign rv_a[g]    = bus.rvalid;
    assign rd_a[g]    = bus.rdata;
    assign men_a[g]   = mem_en;
    assign mwe_a[g]   = mem_we;
    assign maddr_a[g] = mem_addr;
    assign mwd_a[g]   = mem_wdata;
  end

  // Reference model: rotating priority, lock budget, and a schedule of read returns.
  int          m_ptr  = 0;
  int          m_lcnt = 0;
  logic        dv  [2][64];
  int          did [2][64];
  logic [15:0] dd  [2][64];
  logic [15:0] sh_mem [1024];
  logic        sh_wr  [1024];

  always @(negedge clk) begin : compare
    int w, idx, slot;
    logic [2:0]  eg;
    logic [9:0]  ea;
    logic [15:0] ed;
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        chk("rst_gnt", 32'(gnt_a[g]), 32'd0);
        chk("rst_rvalid", 32'(rv_a[g]), 32'd0);
        chk("rst_rdata", 32'(rd_a[g]), 32'd0);
        chk("rst_mem_en", 32'(men_a[g]), 32'd0);
        chk("rst_mem_we", 32'(mwe_a[g]), 32'd0);
        for (int s = 0; s < 64; s++) dv[g][s] = 1'b0;
      end
      m_ptr  = 0;
      m_lcnt = 0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
      if (w >= 0) begin
        eg = 3'(1 << w);
        ea = addr[w*10 +: 10];
        ed = wdata[w*16 +: 16];
      end else begin
        eg = 3'b000;
        ea = 10'h000;
        ed = 16'h0000;
      end
      slot = cyc % 64;
      for (int g = 0; g < 2; g++) begin
        chk("gnt", 32'(gnt_a[g]), 32'(eg));
        chk("mem_en", 32'(men_a[g]), 32'(w >= 0));
        chk("mem_we", 32'(mwe_a[g]), (w >= 0) ? 32'(we[w]) : 32'd0);
        chk("mem_addr", 32'(maddr_a[g]), 32'(ea));
        chk("mem_wdata", 32'(mwd_a[g]), 32'(ed));
        chk("rvalid", 32'(rv_a[g]), dv[g][slot] ? 32'(1 << did[g][slot]) : 32'd0);
        chk("rdata", 32'(rd_a[g]), dv[g][slot] ? 32'(dd[g][slot]) : 32'd0);
        dv[g][slot] = 1'b0;
      end
      if (w >= 0) begin
        if (we[w]) begin
          sh_mem[ea] = ed;
          sh_wr[ea]  = 1'b1;
        end else begin
          for (int g = 0; g < 2; g++) begin
            slot = (cyc + ((g == 0) ? 1 : 3)) % 64;
            dv[g][slot]  = 1'b1;
            did[g][slot] = w;
            dd[g][slot]  = (sh_wr[ea] === 1'b1) ? sh_mem[ea] : pat(int'(ea));
          end
        end
        if (lock[w] && m_lcnt < LOCK_MAX - 1) begin
          m_ptr  = w;
          m_lcnt = m_lcnt + 1;
        end else begin
          m_ptr  = (w + 1) % N;
          m_lcnt = 0;
        end
      end else begin
        m_lcnt = 0;
      end
    end
    cyc++;
  end

  // Requester agents: each presents the head of its queue until granted.
  typedef struct packed { logic w; logic l; logic [9:0] a; logic [15:0] d; } op_t;
  op_t q [3][$];
  logic [2:0]  s_gnt, s_rv0, s_rv1;
  logic [15:0] s_rd0, s_rd1;
  logic        s_men;

  task automatic push(input int i, input logic w, input logic l, input logic [9:0] a, input logic [15:0] d);
    q[i].push_back({w, l, a, d});
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() != 0) begin
        req[i]            = 1'b1;
        we[i]             = q[i][0].w;
        lock[i]           = q[i][0].l;
        addr[i*10 +: 10]  = q[i][0].a;
        wdata[i*16 +: 16] = q[i][0].d;
      end else begin
        req[i]  = 1'b0;
        we[i]   = 1'b0;
        lock[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_gnt = gnt_a[0];
    s_rv0 = rv_a[0];
    s_rd0 = rd_a[0];
    s_rv1 = rv_a[1];
    s_rd1 = rd_a[1];
    s_men = men_a[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (s_gnt[i] && q[i].size() != 0) void'(q[i].pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [2:0]  rv1_log [8];
  logic [15:0] rd1_log [8];
  logic [15:0] exp6 [4];

  initial begin
    rst = 1'b1; req = 3'b000; we = 3'b000; lock = 3'b000;
    addr = 30'd0; wdata = 48'd0;
    exp6 = '{16'hC10A, 16'hC12F, 16'hC1C0, 16'hC1E5};

    step();
    step();
    chk("reset_gnt", 32'(s_gnt), 32'd0);
    chk("reset_mem_en", 32'(s_men), 32'd0);
    chk("reset_rvalid", 32'(s_rv0), 32'd0);
    chk("reset_model_ptr", 32'(m_ptr), 32'd0);
    rst = 1'b0;

    // Three simultaneous reads rotate 0,1,2 and return one cycle later.
    push(0, 1'b0, 1'b0, 10'h000, 16'h0000);
    push(1, 1'b0, 1'b0, 10'h191, 16'h0000);
    push(2, 1'b0, 1'b0, 10'h00A, 16'h0000);
    drive();
    step(); chk("t1_gnt0", 32'(s_gnt), 32'h1);
    step(); chk("t1_gnt1", 32'(s_gnt), 32'h2); chk("t1_rv0", 32'(s_rv0), 32'h1); chk("t1_rd0", 32'(s_rd0), 32'hC35A);
    step(); chk("t1_gnt2", 32'(s_gnt), 32'h4); chk("t1_rv1", 32'(s_rv0), 32'h2); chk("t1_rd1", 32'(s_rd0), 32'hFAAF);
    step(); chk("t1_idle", 32'(s_gnt), 32'h0); chk("t1_rv2", 32'(s_rv0), 32'h4); chk("t1_rd2", 32'(s_rd0), 32'hC228);
    step();

    // A lone requester is granted every cycle.
    for (int j = 0; j < 5; j++) push(1, 1'b0, 1'b0, 10'(32 + j), 16'h0000);
    drive();
    for (int j = 0; j < 5; j++) begin
      step();
      chk("t2_gnt", 32'(s_gnt), 32'h2);
    end
    for (int j = 0; j < 3; j++) step();

    // Locked burst: four grants to requester 0, then 1, then 2.
    do_reset();
    for (int j = 0; j < 4; j++) push(0, 1'b0, 1'b1, 10'(48 + j), 16'h0000);
    push(1, 1'b0, 1'b0, 10'h040, 16'h0000);
    push(2, 1'b0, 1'b0, 10'h041, 16'h0000);
    drive();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t3_locked_gnt", 32'(s_gnt), 32'h1);
    end
    step(); chk("t3_gnt1", 32'(s_gnt), 32'h2);
    step(); chk("t3_gnt2", 32'(s_gnt), 32'h4);
    chk("t3_model_lcnt", 32'(m_lcnt), 32'd0);
    chk("t3_model_ptr", 32'(m_ptr), 32'd0);
    for (int j = 0; j < 3; j++) step();

    // Write then read of the same word on consecutive grants.
    push(1, 1'b1, 1'b0, 10'h191, 16'hBEEF);
    drive();
    step(); chk("t4_wr_gnt", 32'(s_gnt), 32'h2);
    push(0, 1'b0, 1'b0, 10'h191, 16'h0000);
    drive();
    step(); chk("t4_rd_gnt", 32'(s_gnt), 32'h1);
    step(); chk("t4_rv", 32'(s_rv0), 32'h1); chk("t4_rd", 32'(s_rd0), 32'hBEEF);
    for (int j = 0; j < 3; j++) step();

    // Reset right after a read grant discards the return.
    do_reset();
    push(2, 1'b0, 1'b0, 10'h0AA, 16'h0000);
    drive();
    step(); chk("t5_gnt", 32'(s_gnt), 32'h4);
    rst = 1'b1;
    step(); chk("t5_rv_in_rst", 32'(s_rv0), 32'h0); chk("t5_men_in_rst", 32'(s_men), 32'h0);
    step();
    rst = 1'b0;
    step(); chk("t5_rv_lat3", 32'(s_rv1), 32'h0);
    chk("t5_model_ptr", 32'(m_ptr), 32'd0);

    // Back-to-back reads with RD_LAT=3 return in order, three cycles later.
    for (int j = 0; j < 4; j++) push(1, 1'b0, 1'b0, 10'(16 + j), 16'h0000);
    drive();
    for (int j = 0; j < 8; j++) begin
      step();
      rv1_log[j] = s_rv1;
      rd1_log[j] = s_rd1;
    end
    for (int j = 0; j < 8; j++) begin
      if (j >= 3 && j <= 6) begin
        chk("t6_rv", 32'(rv1_log[j]), 32'h2);
        chk("t6_rd", 32'(rd1_log[j]), 32'(exp6[j-3]));
      end else begin
        chk("t6_rv_quiet", 32'(rv1_log[j]), 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end
endmodule
